// File: rtl/cache_mem_arbiter_pkg.sv
// rtl/cache_mem_arbiter_pkg.sv - shared types and defaults for the cache/RAM arbiter
// Contents: ramstate_t (RAM wrapper status), arb_state_t (arbiter grant state),
//           default starvation limit and counter width.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

    // Consecutive dcache completions (with the icache waiting) before the icache is forced in.
    localparam int ARB_STARVE_MAX = 4;
    // Counter must be able to hold ARB_STARVE_MAX.
    localparam int ARB_CNT_W      = 3;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - cache-side request/response and RAM-port bundle
// Signals: icache iREN/iaddr/iwait/iload, dcache dREN/dWEN/daddr/dstore/dwait/dload,
//          RAM ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate.
// Modports: master = arbiter view, slave = caches + RAM wrapper view.
interface cache_mem_arbiter_if;
    import cpu_types_pkg::*;

    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    ramstate_t   ramstate;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one RAM port between icache fills and dcache fill/writeback
// Ports: CLK (rising edge), nRST (async active-low),
//        bus (cache_mem_arbiter_if.master): cache requests/waits/load data and the RAM port.
// One grant is latched per RAM access and held until ACCESS; dcache has default priority,
// the icache is forced in after STARVE_MAX consecutive dcache wins while it was waiting.
module cache_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = ARB_STARVE_MAX,
    parameter int CNT_W      = ARB_CNT_W
) (
    input  logic                CLK,
    input  logic                nRST,
    cache_mem_arbiter_if.master bus
);

    localparam logic [CNT_W-1:0] STARVE_MAX_C = CNT_W'(STARVE_MAX);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    logic dreq;
    logic force_i;
    logic ram_access;

    assign dreq       = bus.dREN | bus.dWEN;
    assign force_i    = bus.iREN & (starve_cnt_q == STARVE_MAX_C);
    assign ram_access = (bus.ramstate == ACCESS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Next state and starvation counter.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        case (state_q)
            IDLE: begin
                if (dreq && !force_i) begin
                    state_d = DGNT;
                end else if (bus.iREN) begin
                    state_d = IGNT;
                end
            end
            IGNT: begin
                // Withdrawal takes precedence: no completion, counter untouched.
                if (!bus.iREN) begin
                    state_d = IDLE;
                end else if (ram_access) begin
                    state_d      = IDLE;
                    starve_cnt_d = '0;
                end
            end
            DGNT: begin
                if (!dreq) begin
                    state_d = IDLE;
                end else if (ram_access) begin
                    state_d = IDLE;
                    // Only a dcache win while the icache is waiting counts toward starvation.
                    if (!bus.iREN) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != STARVE_MAX_C) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: RAM port follows the granted requester; waits drop only on completion.
    always_comb begin
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iload    = bus.ramload;
        bus.dload    = bus.ramload;
        case (state_q)
            IGNT: begin
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;
                if (bus.iREN && ram_access) begin
                    bus.iwait = 1'b0;
                end
            end
            DGNT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                // A write wins over a read when both are requested.
                if (bus.dWEN) begin
                    bus.ramWEN = 1'b1;
                end else begin
                    bus.ramREN = bus.dREN;
                end
                if (dreq && ram_access) begin
                    bus.dwait = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int SMAX = 4;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    cache_mem_arbiter_if bus();

    cache_mem_arbiter #(.STARVE_MAX(SMAX), .CNT_W(3)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference view: who holds the RAM (0 none, 1 icache, 2 dcache) and how many
    // dcache completions in a row happened while the icache was waiting.
    int owner  = 0;
    int dwins  = 0;
    int ipulse = 0;
    int dpulse = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] ds, input ramstate_t rs,
                         input logic [31:0] rl);
        bus.iREN     = ir;
        bus.iaddr    = ia;
        bus.dREN     = dr;
        bus.dWEN     = dw;
        bus.daddr    = da;
        bus.dstore   = ds;
        bus.ramstate = rs;
        bus.ramload  = rl;
    endtask

    task automatic check_outputs();
        logic        ex_iwait, ex_dwait, ex_ren, ex_wen, dreq, acc;
        logic [31:0] ex_addr, ex_store;
        dreq     = bus.dREN | bus.dWEN;
        acc      = (bus.ramstate == ACCESS);
        ex_iwait = 1'b1;
        ex_dwait = 1'b1;
        ex_ren   = 1'b0;
        ex_wen   = 1'b0;
        ex_addr  = 32'd0;
        ex_store = 32'd0;
        if (nRST && owner == 1) begin
            ex_ren   = bus.iREN;
            ex_addr  = bus.iaddr;
            ex_iwait = !(bus.iREN && acc);
        end else if (nRST && owner == 2) begin
            ex_addr  = bus.daddr;
            ex_store = bus.dstore;
            ex_wen   = bus.dWEN;
            ex_ren   = bus.dREN & ~bus.dWEN;
            ex_dwait = !(dreq && acc);
        end
        chk1 ("iwait",    bus.iwait,    ex_iwait);
        chk1 ("dwait",    bus.dwait,    ex_dwait);
        chk1 ("ramREN",   bus.ramREN,   ex_ren);
        chk1 ("ramWEN",   bus.ramWEN,   ex_wen);
        chk32("ramaddr",  bus.ramaddr,  ex_addr);
        chk32("ramstore", bus.ramstore, ex_store);
        chk32("iload",    bus.iload,    bus.ramload);
        chk32("dload",    bus.dload,    bus.ramload);
        if (bus.iwait === 1'b0) ipulse++;
        if (bus.dwait === 1'b0) dpulse++;
    endtask

    task automatic model_update();
        logic dreq, acc;
        dreq = bus.dREN | bus.dWEN;
        acc  = (bus.ramstate == ACCESS);
        if (!nRST) begin
            owner = 0;
            dwins = 0;
        end else if (owner == 0) begin
            if (dreq && !(bus.iREN && dwins == SMAX)) owner = 2;
            else if (bus.iREN)                        owner = 1;
        end else if (owner == 1) begin
            if (!bus.iREN) owner = 0;
            else if (acc) begin
                owner = 0;
                dwins = 0;
            end
        end else begin
            if (!dreq) owner = 0;
            else if (acc) begin
                owner = 0;
                dwins = bus.iREN ? ((dwins < SMAX) ? dwins + 1 : SMAX) : 0;
            end
        end
    endtask

    task automatic settle();
        #1;
        check_outputs();
    endtask

    task automatic tick();
        @(posedge CLK);
        model_update();
        @(negedge CLK);
    endtask

    int d_before_i, d_between, i_done, cyc, ip0, dp0;
    logic ir, dr, dw, hold;
    ramstate_t rs;
    int r;

    initial begin
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, FREE, 32'd0);
        @(negedge CLK);
        settle();
        chk1 ("reset_iwait",  bus.iwait,  1'b1);
        chk1 ("reset_dwait",  bus.dwait,  1'b1);
        chk1 ("reset_ramREN", bus.ramREN, 1'b0);
        chk32("reset_addr",   bus.ramaddr, 32'd0);
        tick();
        nRST = 1'b1;

        // 1. Lone icache read, ACCESS two cycles after grant.
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'd0, 32'd0, FREE, 32'hDEADBEEF);
        settle(); chk1("t1_idle_ren", bus.ramREN, 1'b0); tick();
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'd0, 32'd0, BUSY, 32'hDEADBEEF);
        settle(); chk1("t1_ren", bus.ramREN, 1'b1); chk32("t1_addr", bus.ramaddr, 32'h40); tick();
        settle(); chk1("t1_iwait_busy", bus.iwait, 1'b1); tick();
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'd0, 32'd0, ACCESS, 32'hDEADBEEF);
        settle(); chk1("t1_iwait", bus.iwait, 1'b0); chk32("t1_iload", bus.iload, 32'hDEADBEEF); tick();
        drive(1'b0, 32'h40, 1'b0, 1'b0, 32'd0, 32'd0, FREE, 32'd0);
        settle(); chk1("t1_iwait_after", bus.iwait, 1'b1); tick();

        // 2. Contention: dcache write first, icache after one idle bubble.
        drive(1'b1, 32'h44, 1'b0, 1'b1, 32'h80, 32'h1234, FREE, 32'd0);
        settle(); tick();
        drive(1'b1, 32'h44, 1'b0, 1'b1, 32'h80, 32'h1234, ACCESS, 32'd0);
        settle();
        chk1 ("t2_wen",   bus.ramWEN,   1'b1);
        chk32("t2_store", bus.ramstore, 32'h1234);
        chk1 ("t2_iwait", bus.iwait,    1'b1);
        chk1 ("t2_dwait", bus.dwait,    1'b0);
        tick();
        drive(1'b1, 32'h44, 1'b0, 1'b0, 32'h80, 32'h1234, ACCESS, 32'd0);
        settle(); chk1("t2_bubble", bus.ramREN, 1'b0); tick();
        settle(); chk1("t2_igrant", bus.ramREN, 1'b1); chk1("t2_iwait_done", bus.iwait, 1'b0); tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, FREE, 32'd0);
        settle(); tick();

        // 3. Starvation: both requesting continuously, immediate ACCESS.
        d_before_i = 0; d_between = 0; i_done = 0; cyc = 0;
        drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'd0, ACCESS, 32'h5A5A5A5A);
        while (i_done < 2 && cyc < 60) begin
            ip0 = ipulse; dp0 = dpulse;
            settle();
            if (dpulse > dp0) begin
                if (i_done == 0) d_before_i++;
                else             d_between++;
            end
            if (ipulse > ip0) i_done++;
            tick();
            cyc++;
        end
        chk32("t3_icache_grants", i_done,     32'd2);
        chk32("t3_d_before_i",    d_before_i, 32'd4);
        chk32("t3_d_between",     d_between,  32'd4);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, FREE, 32'd0);
        settle(); tick();

        // 4. Withdrawal in DGNT with an icache read pending.
        drive(1'b1, 32'h300, 1'b1, 1'b0, 32'h400, 32'd0, FREE, 32'd0);
        settle(); tick();
        drive(1'b1, 32'h300, 1'b1, 1'b0, 32'h400, 32'd0, BUSY, 32'd0);
        settle(); chk1("t4_ren", bus.ramREN, 1'b1); tick();
        drive(1'b1, 32'h300, 1'b0, 1'b0, 32'h400, 32'd0, BUSY, 32'd0);
        settle(); chk1("t4_ren_drop", bus.ramREN, 1'b0); chk1("t4_dwait", bus.dwait, 1'b1); tick();
        drive(1'b1, 32'h300, 1'b0, 1'b0, 32'h400, 32'd0, FREE, 32'd0);
        settle(); chk1("t4_idle", bus.ramREN, 1'b0); tick();
        drive(1'b1, 32'h300, 1'b0, 1'b0, 32'h400, 32'd0, ACCESS, 32'd0);
        settle(); chk1("t4_iwait", bus.iwait, 1'b0); chk32("t4_iaddr", bus.ramaddr, 32'h300); tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, FREE, 32'd0);
        settle(); tick();

        // 5. Asynchronous reset while a dcache write is in flight.
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h500, 32'hCAFE, BUSY, 32'd0);
        settle(); tick();
        settle(); chk1("t5_wen", bus.ramWEN, 1'b1);
        #1;
        nRST = 1'b0; owner = 0; dwins = 0;
        #1;
        chk1 ("t5_wen_rst",   bus.ramWEN,  1'b0);
        chk1 ("t5_dwait_rst", bus.dwait,   1'b1);
        chk32("t5_addr_rst",  bus.ramaddr, 32'd0);
        tick();
        nRST = 1'b1;
        settle(); tick();
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h500, 32'hCAFE, ACCESS, 32'd0);
        settle(); chk1("t5_resume", bus.dwait, 1'b0); tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, FREE, 32'd0);
        settle(); tick();

        // 6. Read+write together, ERROR for three cycles then ACCESS.
        drive(1'b0, 32'd0, 1'b1, 1'b1, 32'h600, 32'h77, FREE, 32'd0);
        settle(); tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'd0, 1'b1, 1'b1, 32'h600, 32'h77, ERROR, 32'd0);
            settle();
            chk1("t6_wen",   bus.ramWEN, 1'b1);
            chk1("t6_ren",   bus.ramREN, 1'b0);
            chk1("t6_dwait", bus.dwait,  1'b1);
            tick();
        end
        drive(1'b0, 32'd0, 1'b1, 1'b1, 32'h600, 32'h77, ACCESS, 32'd0);
        settle(); chk1("t6_done", bus.dwait, 1'b0); tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, FREE, 32'd0);
        settle(); chk1("t6_after", bus.dwait, 1'b1); tick();

        // Randomized traffic against the reference view.
        for (int n = 0; n < 3000; n++) begin
            hold = ($urandom_range(0, 7) != 0);
            ir   = (owner == 1) ? hold : ($urandom_range(0, 3) != 0);
            dr   = 1'($urandom_range(0, 1));
            dw   = 1'($urandom_range(0, 1));
            if (owner == 2) begin
                if (!hold) begin
                    dr = 1'b0;
                    dw = 1'b0;
                end else if (!dr && !dw) begin
                    dr = 1'b1;
                end
            end
            r = $urandom_range(0, 9);
            if      (r < 5) rs = ACCESS;
            else if (r < 8) rs = BUSY;
            else if (r < 9) rs = ERROR;
            else            rs = FREE;
            if (rs == ACCESS && ((owner == 1 && !ir) || (owner == 2 && !dr && !dw))) rs = BUSY;
            drive(ir, $urandom, dr, dw, $urandom, $urandom, rs, $urandom);
            settle();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
